// File: rtl/fpu_pkg.sv
// fpu_pkg: single-precision field widths, bias and handshake states shared by the FPU blocks.
package fpu_pkg;
    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int BIAS   = 127;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/fdiv_mant_div.sv
// mant_div: 25-cycle restoring divider producing {1,m1}<<24 / {1,m2}, one quotient bit per cycle MSB first.
module mant_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] dividend,
    input  logic [23:0] divisor,
    output logic [24:0] quotient,
    output logic        done
);
    logic [25:0] rem_q;
    logic [23:0] div_q;
    logic [24:0] quo_q;
    logic [4:0]  cnt_q;
    logic        busy_q, done_q;
    logic        ge;
    logic [24:0] diff;
    // Remainder stays below twice the divisor, so 26 bits never overflow.
    assign ge   = rem_q >= {2'b0, div_q};
    assign diff = ge ? 25'(rem_q - {2'b0, div_q}) : rem_q[24:0];
    always_ff @(posedge clk)
        if (rst) begin
            rem_q  <= '0;
            div_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (start) begin
            rem_q  <= 26'(dividend);
            div_q  <= divisor;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (busy_q) begin
            rem_q  <= {diff, 1'b0};
            quo_q  <= {quo_q[23:0], ge};
            cnt_q  <= cnt_q + 5'd1;
            busy_q <= cnt_q != 5'd24;
            done_q <= cnt_q == 5'd24;
        end
    assign quotient = quo_q;
    assign done     = done_q;
endmodule

// File: rtl/fdiv.sv
// fdiv: truncating single-precision divider with valid/ready handshake and fixed 26-edge latency.
module fdiv
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] y,
    output logic        out_valid,
    input  logic        out_ready
);
    state_t             state_q;
    logic               sy_q;
    logic [EXP_W-1:0]   e1_q, e2_q;
    logic [31:0]        y_q, y_d, inf, zero;
    logic [24:0]        quo;
    logic               div_done, start;
    logic signed [9:0]  ey;
    logic [MANT_W-1:0]  my;
    assign start = state_q == IDLE && in_valid;
    mant_div u_div (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .dividend({1'b1, x1[MANT_W-1:0]}),
        .divisor ({1'b1, x2[MANT_W-1:0]}),
        .quotient(quo),
        .done    (div_done)
    );
    // Quotient lies in [2^23, 2^25); its top bit selects the normalisation shift.
    assign ey   = 10'(e1_q) - 10'(e2_q) + (quo[24] ? 10'(BIAS) : 10'(BIAS - 1));
    assign my   = quo[24] ? quo[23:1] : quo[22:0];
    assign inf  = {sy_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    assign zero = {sy_q, 31'h0};
    assign y_d  = e2_q == '0 ? inf  :
                  e1_q == '0 ? zero :
                  ey <= 0    ? zero :
                  ey >= 255  ? inf  : {sy_q, ey[7:0], my};
    always_ff @(posedge clk)
        if (rst) begin
            state_q <= IDLE;
            y_q     <= '0;
            sy_q    <= 1'b0;
            e1_q    <= '0;
            e2_q    <= '0;
        end else
            case (state_q)
                IDLE: if (in_valid) begin
                    sy_q    <= x1[31] ^ x2[31];
                    e1_q    <= x1[30:23];
                    e2_q    <= x2[30:23];
                    state_q <= CALC;
                end
                CALC: if (div_done) begin
                    y_q     <= y_d;
                    state_q <= DONE;
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign y         = y_q;
endmodule

// File: tb/tb_fdiv.sv
// tb_fdiv: scoreboard bench for fdiv against an integer-division reference model.
module tb_fdiv;
    logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic [31:0] x1 = 0, x2 = 0, y;
    logic        in_ready, out_valid;
    int          total = 0, bad = 0;
    logic [31:0] sbq[$];

    fdiv dut (
        .clk(clk), .rst(rst), .x1(x1), .x2(x2), .in_valid(in_valid),
        .in_ready(in_ready), .y(y), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic sy;
        int ea, eb, ey;
        longint unsigned n, d, q;
        logic [22:0] my;
        sy = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (eb == 0) return {sy, 8'hFF, 23'h0};
        if (ea == 0) return {sy, 31'h0};
        n = 64'({1'b1, a[22:0]}) << 24;
        d = 64'({1'b1, b[22:0]});
        q = n / d;
        if (q[24]) begin my = q[23:1]; ey = ea - eb + 127; end
        else begin my = q[22:0]; ey = ea - eb + 126; end
        if (ey <= 0) return {sy, 31'h0};
        if (ey >= 255) return {sy, 8'hFF, 23'h0};
        return {sy, ey[7:0], my};
    endfunction

    function automatic logic [31:0] rnd_norm();
        logic [31:0] r;
        r = $urandom;
        r[30:23] = 8'($urandom_range(1, 254));
        return r;
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        x1 = a; x2 = b; in_valid = 1;
        sbq.push_back(exp);
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic finish_op(input int stall, input bit poke);
        int lat = 0;
        while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
        check("latency", 32'(lat), 32'd26);
        for (int i = 0; i < stall; i++) begin
            out_ready = 0;
            if (poke) begin in_valid = i[0]; x1 = rnd_norm(); x2 = rnd_norm(); end
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_y", y, sbq[0]);
            if (poke) check("hold_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 0;
        out_ready = 1;
        check("y", y, sbq.pop_front());
        @(negedge clk);
        out_ready = 0;
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_y", y, 32'h0);
        rst = 0;
        @(negedge clk);

        start_op(32'h40C00000, 32'h40000000, 32'h40400000); finish_op(0, 0);
        start_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA); finish_op(1, 0);
        start_op(32'hBF800000, 32'h40000000, 32'hBF000000); finish_op(0, 0);
        start_op(32'h3F800000, 32'h00000000, 32'h7F800000); finish_op(0, 0);
        start_op(32'h00800000, 32'h40000000, 32'h00000000); finish_op(0, 0);
        start_op(32'h00000000, 32'h00000000, 32'h7F800000); finish_op(0, 0);
        start_op(32'h80000000, 32'h3F800000, 32'h80000000); finish_op(0, 0);
        start_op(32'h7F000000, 32'h00800000, 32'h7F800000); finish_op(0, 0);

        // Long DONE stall with in_valid pulses that must not be taken.
        start_op(32'h40C00000, 32'h40000000, 32'h40400000); finish_op(10, 1);
        repeat (30) @(negedge clk);
        check("no_phantom", 32'(out_valid), 32'd0);

        // Abort mid-calculation; the discarded result must never appear.
        start_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA);
        repeat (9) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("abort_ready", 32'(in_ready), 32'd1);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_y", y, 32'h0);
        void'(sbq.pop_back());
        repeat (30) @(negedge clk);
        check("abort_silent", 32'(out_valid), 32'd0);
        start_op(32'hBF800000, 32'h40000000, 32'hBF000000); finish_op(0, 0);

        for (int k = 0; k < 1500; k++) begin
            logic [31:0] a, b;
            a = rnd_norm();
            b = rnd_norm();
            start_op(a, b, ref_div(a, b));
            finish_op($urandom_range(0, 3), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
